// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment codes are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int   PWM_STEPS = 16;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed NDIG-digit common-anode display scanner with frame-synchronous
// input latching, leading-zero blanking, brightness PWM and dead time.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SUB_DIV = 3125
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4*NDIG-1:0] dat,
    input  logic [NDIG-1:0]   dp,
    input  logic              blank_lz,
    input  logic [3:0]        bright,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              seg_p,
    output logic              ce1ms
);

    localparam int PRE_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SUB_W = $clog2(PWM_STEPS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PWM_STEPS - 1);

    logic [PRE_W-1:0]  pre;
    logic [SUB_W-1:0]  sub;
    logic [IDX_W-1:0]  idx;
    logic              sub_tick;
    logic              slot_end;
    logic              frame_end;
    logic              slot_start;

    logic [4*NDIG-1:0] dat_sh;
    logic [NDIG-1:0]   dp_sh;
    logic              blank_lz_sh;

    logic [NDIG-1:0]   blank_vec;
    logic              zero_above;
    logic [3:0]        nibble_sel;
    seg_t              dec_seg;

    logic [NDIG-1:0]   an_d;
    seg_t              seg_d;
    logic              seg_p_d;

    assign sub_tick  = (pre == PRE_LAST);
    assign slot_end  = sub_tick && (sub == SUB_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            sub <= '0;
            idx <= '0;
        end else begin
            pre <= sub_tick ? '0 : pre + 1'b1;
            if (sub_tick)
                sub <= sub + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // NOTE: the shadows are plain flops, not a memory, and are reset so the
    // first frame after reset shows a defined "0" pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dat_sh      <= '0;
            dp_sh       <= '0;
            blank_lz_sh <= 1'b0;
        end else if (frame_end) begin
            dat_sh      <= dat;
            dp_sh       <= dp;
            blank_lz_sh <= blank_lz;
        end
    end

    // A digit is blank only while every more-significant nibble is also zero.
    // NOTE: zero_above and blank_vec are fully assigned on every pass, so no
    // latch can be inferred from this loop.
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above   = zero_above && (dat_sh[4*i +: 4] == 4'h0);
            blank_vec[i] = blank_lz_sh && zero_above && (i != 0);
        end
    end

    assign nibble_sel = dat_sh[{idx, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble (nibble_sel),
        .seg    (dec_seg)
    );

    // Sub-tick 0 is dead time for every digit; bright is used live.
    always_comb begin
        an_d = '1;
        if ((sub != '0) && (sub <= bright))
            an_d[idx] = 1'b0;
        seg_d   = blank_vec[idx] ? SEG_BLANK : dec_seg;
        seg_p_d = ~dp_sh[idx];
    end

    // slot_start delays the strobe so it lines up with the registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            seg_p      <= 1'b1;
            slot_start <= 1'b0;
            ce1ms      <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            seg_p      <= seg_p_d;
            slot_start <= slot_end;
            ce1ms      <= slot_start;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at NDIG = 4, SUB_DIV = 2 (32 clk slot).
module tb_seg7_scan_ctrl;

    localparam int NDIG    = 4;
    localparam int SUB_DIV = 2;
    localparam int SLOT    = 16 * SUB_DIV;
    localparam int NVEC    = 36;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] dat;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        seg_p;
    logic        ce1ms;

    int checks    = 0;
    int errors    = 0;
    int pulse_cnt = 0;
    int kcnt      = 0;

    typedef struct {
        int          idx;
        int          k;
        logic [15:0] dat;
        logic [3:0]  dp;
        logic        blz;
        logic [3:0]  bright;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        seg_p;
    } vec_t;

    vec_t vecs [NVEC];

    seg7_scan_ctrl #(.NDIG(NDIG), .SUB_DIV(SUB_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .dat      (dat),
        .dp       (dp),
        .blank_lz (blank_lz),
        .bright   (bright),
        .an       (an),
        .seg      (seg),
        .seg_p    (seg_p),
        .ce1ms    (ce1ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Input sets: A = scan order, B = blanking, C = B at bright 4, D = all-zero.
    function automatic vec_t mk(input int idx, input int k, input int set,
                                input logic [3:0] an_e, input logic [6:0] seg_e,
                                input logic p_e);
        vec_t v;
        v.idx = idx;  v.k = k;  v.an = an_e;  v.seg = seg_e;  v.seg_p = p_e;
        case (set)
            0:       begin v.dat = 16'h1A8F; v.dp = 4'b0000; v.blz = 1'b0; v.bright = 4'd15; end
            1:       begin v.dat = 16'h0050; v.dp = 4'b1000; v.blz = 1'b1; v.bright = 4'd15; end
            2:       begin v.dat = 16'h0050; v.dp = 4'b1000; v.blz = 1'b1; v.bright = 4'd4;  end
            default: begin v.dat = 16'h0000; v.dp = 4'b0001; v.blz = 1'b1; v.bright = 4'd15; end
        endcase
        return v;
    endfunction

    task automatic wait_ce();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * SLOT && !seen; i++) begin
            @(negedge clk);
            if (ce1ms) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ce1ms_timeout actual=0 required=1");
        end
        pulse_cnt++;
        kcnt = 0;
    endtask

    task automatic advance(input int k);
        while (kcnt < k) begin
            @(negedge clk);
            kcnt++;
        end
    endtask

    // Counts clocks from reset release to the first strobe; peeks at the
    // pre-load display on the way.
    task automatic first_ce(input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        while (n < 3 * SLOT && !seen) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                check({tag, "_preload_an"}, an, 4'b1110);
                check({tag, "_preload_seg"}, seg, 7'h40);
            end
            if (ce1ms) seen = 1'b1;
        end
        check({tag, "_first_ce_clk"}, n - 1, SLOT);
        pulse_cnt = 1;
        kcnt = 0;
    endtask

    initial begin
        int n;
        int lit;
        bit seen;

        vecs[0]  = mk(0,  0, 0, 4'hF, 7'h0E, 1'b1);
        vecs[1]  = mk(0,  2, 0, 4'hE, 7'h0E, 1'b1);
        vecs[2]  = mk(0, 31, 0, 4'hE, 7'h0E, 1'b1);
        vecs[3]  = mk(1,  0, 0, 4'hF, 7'h00, 1'b1);
        vecs[4]  = mk(1,  2, 0, 4'hD, 7'h00, 1'b1);
        vecs[5]  = mk(2,  0, 0, 4'hF, 7'h08, 1'b1);
        vecs[6]  = mk(2,  2, 0, 4'hB, 7'h08, 1'b1);
        vecs[7]  = mk(2,  3, 1, 4'hB, 7'h08, 1'b1);
        vecs[8]  = mk(3,  0, 1, 4'hF, 7'h79, 1'b1);
        vecs[9]  = mk(3,  2, 1, 4'h7, 7'h79, 1'b1);
        vecs[10] = mk(3, 31, 1, 4'h7, 7'h79, 1'b1);
        vecs[11] = mk(0,  0, 1, 4'hF, 7'h40, 1'b1);
        vecs[12] = mk(0,  2, 1, 4'hE, 7'h40, 1'b1);
        vecs[13] = mk(1,  0, 1, 4'hF, 7'h12, 1'b1);
        vecs[14] = mk(1,  2, 1, 4'hD, 7'h12, 1'b1);
        vecs[15] = mk(2,  0, 1, 4'hF, 7'h7F, 1'b1);
        vecs[16] = mk(2,  2, 1, 4'hB, 7'h7F, 1'b1);
        vecs[17] = mk(3,  0, 1, 4'hF, 7'h7F, 1'b0);
        vecs[18] = mk(3,  2, 1, 4'h7, 7'h7F, 1'b0);
        vecs[19] = mk(0,  0, 2, 4'hF, 7'h40, 1'b1);
        vecs[20] = mk(0,  1, 2, 4'hF, 7'h40, 1'b1);
        vecs[21] = mk(0,  2, 2, 4'hE, 7'h40, 1'b1);
        vecs[22] = mk(0,  9, 2, 4'hE, 7'h40, 1'b1);
        vecs[23] = mk(0, 10, 2, 4'hF, 7'h40, 1'b1);
        vecs[24] = mk(1,  0, 2, 4'hF, 7'h12, 1'b1);
        vecs[25] = mk(2,  0, 2, 4'hF, 7'h7F, 1'b1);
        vecs[26] = mk(3,  0, 2, 4'hF, 7'h7F, 1'b0);
        vecs[27] = mk(3,  2, 3, 4'h7, 7'h7F, 1'b0);
        vecs[28] = mk(3, 20, 3, 4'h7, 7'h7F, 1'b0);
        vecs[29] = mk(0,  0, 3, 4'hF, 7'h40, 1'b0);
        vecs[30] = mk(0,  2, 3, 4'hE, 7'h40, 1'b0);
        vecs[31] = mk(1,  0, 3, 4'hF, 7'h7F, 1'b1);
        vecs[32] = mk(1,  2, 3, 4'hD, 7'h7F, 1'b1);
        vecs[33] = mk(2,  0, 3, 4'hF, 7'h7F, 1'b1);
        vecs[34] = mk(3,  0, 3, 4'hF, 7'h7F, 1'b1);
        vecs[35] = mk(3,  2, 3, 4'h7, 7'h7F, 1'b1);

        dat      = 16'h1A8F;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        bright   = 4'd15;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an",    an,    4'hF);
        check("rst_seg",   seg,   7'h7F);
        check("rst_seg_p", seg_p, 1'b1);
        check("rst_ce1ms", ce1ms, 1'b0);

        reset_n = 1'b1;
        first_ce("boot");
        @(negedge clk);
        kcnt = 1;
        check("ce1ms_width", ce1ms, 1'b0);

        n = 1;
        seen = 1'b0;
        while (n < 2 * SLOT && !seen) begin
            @(negedge clk);
            n++;
            if (ce1ms) seen = 1'b1;
        end
        check("ce1ms_period", n, SLOT);
        pulse_cnt = 2;
        kcnt = 0;
        wait_ce();

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].k == 0) begin
                wait_ce();
                check($sformatf("v%0d_slot", i), pulse_cnt % NDIG, vecs[i].idx);
            end else begin
                advance(vecs[i].k);
            end
            dat      = vecs[i].dat;
            dp       = vecs[i].dp;
            blank_lz = vecs[i].blz;
            bright   = vecs[i].bright;
            check($sformatf("v%0d_an", i),    an,    vecs[i].an);
            check($sformatf("v%0d_seg", i),   seg,   vecs[i].seg);
            check($sformatf("v%0d_seg_p", i), seg_p, vecs[i].seg_p);
        end

        // Frame latched at the coming wrap: 1234, no blanking, bright 4.
        dat      = 16'h1234;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        bright   = 4'd4;
        wait_ce();
        wait_ce();
        lit = 0;
        for (int k = 0; k < SLOT; k++) begin
            if (k > 0) @(negedge clk);
            if (an != 4'hF) lit++;
        end
        check("bright4_lit_clk", lit, 8);

        wait_ce();
        bright = 4'd0;
        lit = 0;
        for (int k = 0; k < SLOT; k++) begin
            if (k > 0) @(negedge clk);
            if (an != 4'hF) lit++;
        end
        check("bright0_lit_clk", lit, 0);

        wait_ce();
        bright = 4'd15;
        advance(10);
        check("pre_rst_an",  an,  4'h7);
        check("pre_rst_seg", seg, 7'h79);

        reset_n = 1'b0;
        #1;
        check("midslot_rst_an",    an,    4'hF);
        check("midslot_rst_seg",   seg,   7'h7F);
        check("midslot_rst_seg_p", seg_p, 1'b1);
        check("midslot_rst_ce1ms", ce1ms, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        first_ce("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller; successor to the fixed 4-digit display driver. It scans NDIG common-anode digits from one packed hex data word. Added over the fixed driver: per-digit decimal points, leading-zero blanking, 16-level brightness PWM, anti-ghost dead time and frame-synchronous input latching so digits never tear. It sits between the data generator and the board pins and exports the 1 ms strobe as before.

## Interface
- NDIG, 4, number of digits (1..8)
- SUB_DIV, 3125, clocks per PWM sub-tick; digit slot = 16 sub-ticks (50 MHz → 1 ms slot)
- clk  in  1  system clock (50 MHz on the board)
- reset_n  in  1  asynchronous, active-low reset
- dat  in  4*NDIG  hex nibbles; nibble i = dat[4i+3:4i], digit 0 = rightmost
- dp  in  NDIG  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = suppress leading zeros
- bright  in  4  brightness, 0 = dark, 15 = max
- an  out  NDIG  anodes, active low
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- seg_p  out  1  decimal point, active low
- ce1ms  out  1  one-clock pulse per digit slot

## Operation
- Prescaler pre counts 0..SUB_DIV-1; sub_tick = (pre == SUB_DIV-1).
- Sub-tick counter sub (4 bit) increments on sub_tick, wraps 15→0.
- Slot end = sub_tick while sub == 15: digit index idx advances, wraps NDIG-1→0; ce1ms pulses.
- Frame latch: on the slot end where idx wraps to 0, dat, dp and blank_lz are sampled into shadow registers. Display always uses shadows. Input changes mid-frame appear only from the next frame.
- Leading-zero blanking: digit i (i ≥ 1) is blank when shadow blank_lz = 1 and all shadow nibbles NDIG-1..i are 0. Digit 0 is never blank.
- A blank digit drives seg = 7'h7F. Its dp still follows shadow dp[i].
- PWM/dead time: the anode for idx is low only when 1 ≤ sub ≤ bright. sub = 0 is always dead time, with all anodes high. bright is sampled live, not latched.
- Segment codes are active low, standard hex: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- an, seg and seg_p are registered.

## Timing
- Reset values: an all 1, seg 7'h7F, seg_p 1, ce1ms 0. Internal state: pre = sub = idx = 0; shadows = 0.
- Assertion of reset_n low forces these values immediately, including mid-slot.
- The first ce1ms pulse occurs 16·SUB_DIV clocks after reset release. The period is exactly 16·SUB_DIV clocks.
- Outputs lag internal idx/sub by exactly one clock. The ce1ms pulse coincides with the first output cycle of the new slot, which is dead time.
- The first shadow load happens at the NDIG-th ce1ms. Before it, the display shows shadow 0 (digit 0 = "0", others follow blank_lz = 0 → "0").
- A dat change coincident with the frame-latch edge is captured.

## Structure
- Package seg7_pkg holds:
  - the 16-entry active-low hex segment table;
  - SEG_BLANK = 7'h7F;
  - the PWM_STEPS = 16 constant.
- Sub-module seg7_hex_decoder: combinational nibble → seg lookup from the package. It is instantiated once, on the shadow nibble selected by idx.
- Everything else lives in seg7_scan_ctrl: prescaler, counters, shadows, blanking logic, output registers.

## Test plan
- Test configuration: NDIG = 4, SUB_DIV = 2, so slot = 32 clk and frame = 128 clk.
- Reset/cadence: release reset_n, hold stable → outputs at reset values. First ce1ms at clk 32, then every 32 clk.
- Scan order: dat = 16'h1A8F, bright = 15, first frame after load → during sub 1..15:
  - idx 0: an = 4'b1110, seg = 7'h0E;
  - idx 1: seg = 7'h00;
  - idx 2: seg = 7'h08;
  - idx 3: seg = 7'h79.
  - At sub 0: an = 4'b1111.
- Blanking: dat = 16'h0050, blank_lz = 1, dp = 4'b1000 → digit 3 shows seg = 7'h7F with seg_p = 0. Digit 2 blank, digit 1 = "5", digit 0 = "0".
- Brightness: bright = 0 → an stays 4'hF. bright = 4 → an low for exactly 4 sub-ticks (8 clk) per slot.
- Tearing: change dat during idx 2 → the new value appears only after the next idx wrap to 0.
- Reset mid-slot: pull reset_n low at clk 50 → an = 4'hF and seg = 7'h7F in the same cycle. After release, the first ce1ms arrives 32 clk later.
